inst_buffer: RTL



---
 rtl/inst_buffer_pkg.sv | 19 +
 rtl/ibuf_ram.sv | 30 +++
 rtl/inst_buffer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
// The optional INST_BUF_BYPASS_EN build uses the same types.
package inst_buffer_pkg;

    localparam int DEFAULT_DEPTH = 8;

    // Exception flags of an instruction that carries no fetch-side exception.
    localparam logic [1:0] EXCEPTION_NOP = 2'b00;

    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     inst;
        logic            pre_taken;
        logic [31:0]     pre_addr;
        logic [1:0]      is_exception;
        logic [1:0][6:0] exception_cause;
    } inst_buf_entry_t;

endpackage

// File: rtl/ibuf_ram.sv
// Entry storage for inst_buffer: two write ports and one combinational read port.
// The two write addresses are never equal in the same cycle.
module ibuf_ram
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [PTR_W-1:0] waddr0,
    input  inst_buf_entry_t  wdata0,
    input  logic             we1,
    input  logic [PTR_W-1:0] waddr1,
    input  inst_buf_entry_t  wdata1,
    input  logic [PTR_W-1:0] raddr,
    output inst_buf_entry_t  rdata
);

    inst_buf_entry_t mem [DEPTH];

    // Contents need no reset; the count qualifies every read.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer: accepts up to two fetched instructions per cycle, issues one per cycle.
// Define INST_BUF_BYPASS_EN to forward fetch slot 0 straight to the output when empty.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [1:0]            fetch_valid,
    input  logic [1:0][31:0]      fetch_pc,
    input  logic [1:0][31:0]      fetch_inst,
    input  logic [1:0]            fetch_pre_taken,
    input  logic [1:0][31:0]      fetch_pre_addr,
    input  logic [1:0][1:0]       fetch_is_exception,
    input  logic [1:0][1:0][6:0]  fetch_exception_cause,
    output logic                  fetch_ready,
    input  logic                  dec_ready,
    output logic                  valid,
    output logic [31:0]           pc,
    output logic [31:0]           inst,
    output logic                  pre_taken,
    output logic [31:0]           pre_addr,
    output logic [1:0]            is_exception,
    output logic [1:0][6:0]       exception_cause,
    output logic [PTR_W:0]        count
);

    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

    logic [PTR_W-1:0]     head_reg, head_next;
    logic [PTR_W-1:0]     tail_reg, tail_next;
    logic [PTR_W:0]       count_reg, count_next;
    inst_buf_entry_t [1:0] slot_entry;
    inst_buf_entry_t      head_entry;
    inst_buf_entry_t      out_entry;
    logic                 stored_valid;
    logic                 pop;
    logic                 bypass_active;
    logic                 bypass_take;
    logic [1:0]           wr_en;
    logic [PTR_W-1:0]     waddr1;
    logic [1:0]           push_cnt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_entry[gi] = '{
                pc:              fetch_pc[gi],
                inst:            fetch_inst[gi],
                pre_taken:       fetch_pre_taken[gi],
                pre_addr:        fetch_pre_addr[gi],
                is_exception:    fetch_is_exception[gi],
                exception_cause: fetch_exception_cause[gi]
            };
        end
    endgenerate

    // Two free slots are required regardless of how many fetch slots are valid.
    assign fetch_ready  = (count_reg <= READY_MAX);
    assign stored_valid = (count_reg != '0) && !flush;

`ifdef INST_BUF_BYPASS_EN
    assign bypass_active = (count_reg == '0) && !flush && fetch_valid[0] && fetch_ready;
`else
    assign bypass_active = 1'b0;
`endif

    // A forwarded slot 0 that the decoder takes never occupies storage.
    assign bypass_take = bypass_active && dec_ready;
    assign valid       = stored_valid || bypass_active;
    assign pop         = stored_valid && dec_ready;
    assign out_entry   = bypass_active ? slot_entry[0] : head_entry;

    // Valid slots are packed from the tail, so a lone slot 1 lands at the tail.
    assign wr_en[0] = fetch_ready && !flush && fetch_valid[0] && !bypass_take;
    assign wr_en[1] = fetch_ready && !flush && fetch_valid[1];
    assign waddr1   = wr_en[0] ? tail_reg + PTR_W'(1) : tail_reg;
    assign push_cnt = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            head_next  = head_reg + PTR_W'(pop);
            tail_next  = tail_reg + PTR_W'(push_cnt);
            count_next = count_reg + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    ibuf_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk    (clk),
        .we0    (wr_en[0]),
        .waddr0 (tail_reg),
        .wdata0 (slot_entry[0]),
        .we1    (wr_en[1]),
        .waddr1 (waddr1),
        .wdata1 (slot_entry[1]),
        .raddr  (head_reg),
        .rdata  (head_entry)
    );

    assign pc              = out_entry.pc;
    assign inst            = out_entry.inst;
    assign pre_taken       = out_entry.pre_taken;
    assign pre_addr        = out_entry.pre_addr;
    assign is_exception    = out_entry.is_exception;
    assign exception_cause = out_entry.exception_cause;
    assign count           = count_reg;

endmodule
